instr_encoder: RTL

- Encodes decoded instruction fields back into 32-bit RV32I words: the inverse of the control-unit decode path.
- Covers the same five opcode classes the control unit recognises: R-type 0x33, I-ALU 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63.
- Accepts one field set per handshake and writes the encoded word into instruction memory at an auto-incrementing address.
- Serves as the test/boot-time program loader for the core's imem.

---
 rtl/instr_encoder.sv | 78 +++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into instruction words and streams them into imem.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err_illegal,
    output logic              err_imm
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t      state;
    logic [31:0] enc;
    logic        accept;
    logic        legal;
    assign busy     = state == LOAD;
    assign full     = count == (ADDR_W+1)'(DEPTH);
    assign in_ready = busy && !full && !start;
    assign accept   = in_valid && in_ready;
    assign legal    = in_class < 3'd5;
    // Branch offsets are halfword-aligned, so imm[0] never reaches the word.
    always_comb begin
        enc = in_class == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'h33}
            : in_class == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13}
            : in_class == 3'd2 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h03}
            : in_class == 3'd3 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'h23}
            : {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'h63};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
            err_imm     <= 1'b0;
        end else begin
            imem_we <= accept && legal;
            if (start) begin
                state       <= LOAD;
                count       <= '0;
                err_illegal <= 1'b0;
                err_imm     <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    imem_addr  <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
                    imem_wdata <= enc;
                    count      <= count + 1'b1;
                end else begin
                    err_illegal <= 1'b1;
                end
                if (in_class == 3'd4 && in_imm[0]) err_imm <= 1'b1;
                if (finish || (legal && count == (ADDR_W+1)'(DEPTH-1))) state <= DONE;
            end else if (busy && finish) begin
                state <= DONE;
            end
        end
    end
endmodule
